// File: rtl/framebuffer_write_scheduler_if.sv
// Ray pixel stream into the scheduler and the BRAM write port A it drives.
interface framebuffer_write_scheduler_if #(
    parameter int PIXEL_WIDTH = 16,
    parameter int ADDR_BITS   = 18
);
    logic                   ray_valid;
    logic                   ray_ready;
    logic [15:0]            ray_x;
    logic [15:0]            ray_y;
    logic [PIXEL_WIDTH-1:0] ray_pixel;
    logic                   bram_we;
    logic [ADDR_BITS-1:0]   bram_addr;
    logic [PIXEL_WIDTH-1:0] bram_din;

    modport slave (
        input  ray_valid, ray_x, ray_y, ray_pixel,
        output ray_ready, bram_we, bram_addr, bram_din
    );

    modport master (
        output ray_valid, ray_x, ray_y, ray_pixel,
        input  ray_ready, bram_we, bram_addr, bram_din
    );
endinterface

// File: rtl/framebuffer_write_scheduler.sv
// Arbitrates framebuffer write port A between the clear engine and the ray pixel
// stream; tracks render time, completion and write/drop counts.
module framebuffer_write_scheduler #(
    parameter int FRAME_WIDTH  = 512,
    parameter int FRAME_HEIGHT = 384,
    parameter int ADDR_BITS    = 18,
    parameter int PIXEL_WIDTH  = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_start,
    input  logic [PIXEL_WIDTH-1:0] clear_color,
    output logic                   clear_busy,
    framebuffer_write_scheduler_if.slave fb,
    output logic                   frame_done,
    output logic [31:0]            render_cycles,
    output logic [31:0]            write_count,
    output logic [15:0]            drop_count
);
    localparam int                   NPIX      = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int                   PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [31:0]          FW32      = 32'(FRAME_WIDTH);
    localparam logic [31:0]          FH32      = 32'(FRAME_HEIGHT);
    localparam logic [31:0]          LAST32    = 32'(NPIX - 1);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NPIX - 1);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);
    localparam logic [PTR_W:0]       PTR_ONE   = (PTR_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, CLEAR, RENDER} state_t;

    typedef struct packed {
        logic [15:0]            x;
        logic [15:0]            y;
        logic [PIXEL_WIDTH-1:0] pixel;
    } ray_t;

    state_t state, state_nx;
    ray_t   mem [FIFO_DEPTH];
    ray_t   ray_in, head;
    logic [PTR_W:0]         wr_ptr, rd_ptr;
    logic [PIXEL_WIDTH-1:0] clr_color;
    logic [31:0]            lin_addr;
    logic fifo_empty, fifo_full, push, clear_go, drain_ok, bypass, pop_fifo, enq;
    logic head_vld, in_range, wr_ray, last_px, clear_last, armed, started;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign fb.ray_ready = !fifo_full;
    assign push       = fb.ray_valid && fb.ray_ready;
    assign clear_go   = clear_start && (state != CLEAR);
    assign clear_busy = (state == CLEAR);
    assign clear_last = (state == CLEAR) && (fb.bram_addr == LAST_ADDR);

    // The clear engine takes the port the cycle after clear_start, so the
    // request cycle must not launch a ray write either.
    assign drain_ok = (state != CLEAR) && !clear_go;
    // Fall-through: a pixel arriving at an empty FIFO goes straight to the port.
    assign bypass   = fifo_empty && push && drain_ok;
    assign pop_fifo = !fifo_empty && drain_ok;
    assign enq      = push && !bypass;
    assign head_vld = pop_fifo || bypass;

    assign ray_in   = '{x: fb.ray_x, y: fb.ray_y, pixel: fb.ray_pixel};
    assign head     = fifo_empty ? ray_in : mem[rd_ptr[PTR_W-1:0]];
    assign in_range = (32'(head.x) < FW32) && (32'(head.y) < FH32);
    assign lin_addr = FW32 * 32'(head.y) + 32'(head.x);
    assign wr_ray   = head_vld && in_range;
    assign last_px  = wr_ray && (lin_addr == LAST32);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (clear_start) state_nx = CLEAR;
                     else if (push)   state_nx = RENDER;
            RENDER:  if (clear_start)     state_nx = CLEAR;
                     else if (frame_done) state_nx = IDLE;
            CLEAR:   if (clear_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq)      wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_fifo) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr[PTR_W-1:0]] <= ray_in;
    end

    // During CLEAR the registered address doubles as the clear cursor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb.bram_we   <= 1'b0;
            fb.bram_addr <= '0;
            fb.bram_din  <= '0;
            clr_color    <= '0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= last_px && armed;
            if (clear_go) begin
                fb.bram_we   <= 1'b1;
                fb.bram_addr <= '0;
                fb.bram_din  <= clear_color;
                clr_color    <= clear_color;
            end else if (state == CLEAR) begin
                if (clear_last) begin
                    fb.bram_we <= 1'b0;
                end else begin
                    fb.bram_we   <= 1'b1;
                    fb.bram_addr <= fb.bram_addr + ADDR_ONE;
                    fb.bram_din  <= clr_color;
                end
            end else begin
                fb.bram_we <= wr_ray;
                if (wr_ray) begin
                    fb.bram_addr <= lin_addr[ADDR_BITS-1:0];
                    fb.bram_din  <= head.pixel;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed         <= 1'b1;
            started       <= 1'b0;
            render_cycles <= '0;
            write_count   <= '0;
            drop_count    <= '0;
        end else begin
            if (clear_go) begin
                armed         <= 1'b1;
                started       <= push;
                render_cycles <= {31'd0, push};
                write_count   <= '0;
            end else begin
                if (last_px) armed <= 1'b0;
                if (armed && push) started <= 1'b1;
                if (armed && (started || push) && render_cycles != '1)
                    render_cycles <= render_cycles + 32'd1;
                if (wr_ray) write_count <= write_count + 32'd1;
            end
            if (head_vld && !in_range && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_framebuffer_write_scheduler.sv
// Random and directed stimulus against a queue-based model of the write scheduler.
module tb_framebuffer_write_scheduler;
    localparam int FW = 4, FH = 3, NPIX = FW * FH, AB = 18, PXW = 16, DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clear_start = 1'b0;
    logic [PXW-1:0]  clear_color = '0;
    logic            clear_busy, frame_done;
    logic [31:0]     render_cycles, write_count;
    logic [15:0]     drop_count;

    framebuffer_write_scheduler_if #(.PIXEL_WIDTH(PXW), .ADDR_BITS(AB)) fb();

    framebuffer_write_scheduler #(
        .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .ADDR_BITS(AB),
        .PIXEL_WIDTH(PXW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear_start(clear_start), .clear_color(clear_color),
        .clear_busy(clear_busy), .fb(fb), .frame_done(frame_done),
        .render_cycles(render_cycles), .write_count(write_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {int x; int y; int pix; int gap;} px_t;
    px_t src[$];
    px_t mq[$];
    int  gap_left = 0;
    int  checks = 0, errors = 0;
    bit  m_clearing, m_armed, m_started, e_we, e_done;
    int  m_clr, m_color, e_addr, e_din, m_wc, m_dc, cyc, c_first, c_done;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_clearing = 0; m_armed = 1; m_started = 0; e_we = 0; e_done = 0;
        m_wc = 0; m_dc = 0; c_first = 0; c_done = 0;
    endtask

    function automatic int exp_rc();
        if (!m_started) return 0;
        return m_armed ? cyc - c_first : c_done - c_first;
    endfunction

    task automatic drive();
        if (src.size() > 0 && gap_left == 0) begin
            fb.ray_valid = 1'b1;
            fb.ray_x     = 16'(src[0].x);
            fb.ray_y     = 16'(src[0].y);
            fb.ray_pixel = 16'(src[0].pix);
        end else begin
            fb.ray_valid = 1'b0;
        end
    endtask

    task automatic add_px(input int x, input int y, input int pix, input int gap);
        px_t p;
        p = '{x: x, y: y, pix: pix, gap: gap};
        if (src.size() == 0) gap_left = gap;
        src.push_back(p);
        drive();
    endtask

    task automatic chk_reset_state();
        chk("rst_bram_we", fb.bram_we, 0);
        chk("rst_clear_busy", clear_busy, 0);
        chk("rst_ray_ready", fb.ray_ready, 1);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_render_cycles", render_cycles, 0);
        chk("rst_write_count", write_count, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_bram_addr", fb.bram_addr, 0);
    endtask

    // One clock: model the cycle just ending, then compare the new outputs.
    task automatic tick();
        bit  rdy, acc, cs, drain;
        px_t p;
        int  old;
        rdy = mq.size() < DEPTH;
        chk("ray_ready", fb.ray_ready, rdy);
        acc   = fb.ray_valid && rdy;
        cs    = clear_start;
        drain = !m_clearing && !cs;
        if (acc) p = src[0];
        @(posedge clk);
        old = cyc;
        cyc++;
        e_we = 0; e_done = 0;
        if (m_clearing) begin
            if (m_clr < NPIX - 1) begin
                m_clr++; e_we = 1; e_addr = m_clr; e_din = m_color;
            end else m_clearing = 0;
        end else if (cs) begin
            m_clearing = 1; m_clr = 0; m_color = int'(clear_color);
            e_we = 1; e_addr = 0; e_din = m_color;
            m_wc = 0; m_armed = 1; m_started = 0;
        end
        if (acc) begin
            mq.push_back(p);
            if (m_armed && !m_started) begin m_started = 1; c_first = old; end
        end
        if (drain && mq.size() > 0) begin
            p = mq.pop_front();
            if (p.x < FW && p.y < FH) begin
                e_we = 1; e_addr = p.y * FW + p.x; e_din = p.pix; m_wc++;
                if (e_addr == NPIX - 1 && m_armed) begin
                    e_done = 1; m_armed = 0; c_done = cyc;
                end
            end else if (m_dc < 65535) m_dc++;
        end
        #1;
        chk("clear_busy", clear_busy, m_clearing);
        chk("bram_we", fb.bram_we, e_we);
        if (e_we) begin
            chk("bram_addr", fb.bram_addr, e_addr);
            chk("bram_din", fb.bram_din, e_din);
        end
        chk("frame_done", frame_done, e_done);
        chk("render_cycles", render_cycles, exp_rc());
        chk("write_count", write_count, m_wc);
        chk("drop_count", drop_count, m_dc);
        if (acc) begin
            void'(src.pop_front());
            gap_left = (src.size() > 0) ? src[0].gap : 0;
        end else if (!fb.ray_valid && gap_left > 0) gap_left--;
        clear_start = 1'b0;
        drive();
    endtask

    task automatic run_drain(input int max);
        for (int i = 0; i < max && (src.size() > 0 || mq.size() > 0 || m_clearing); i++) tick();
        chk("drain_bound", src.size() + mq.size() + int'(m_clearing), 0);
        repeat (3) tick();
    endtask

    task automatic pulse_clear(input logic [PXW-1:0] color);
        clear_color = color;
        clear_start = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not terminate");
        $fatal(1);
    end

    initial begin
        fb.ray_valid = 1'b0; fb.ray_x = '0; fb.ray_y = '0; fb.ray_pixel = '0;
        cyc = 0;
        #3;
        chk_reset_state();
        model_reset();
        #4 rst_n = 1'b1;

        // Full frame streamed back-to-back, colour = index.
        for (int i = 0; i < NPIX; i++) add_px(i % FW, i / FW, i, 0);
        run_drain(60);

        pulse_clear(16'h0ABC);
        run_drain(60);

        // Clear request in the same cycle as a burst that overfills the FIFO.
        add_px(1, 1, 16'h0101, 0);
        add_px(2, 1, 16'h0102, 0);
        add_px(3, 1, 16'h0103, 0);
        add_px(0, 2, 16'h0104, 0);
        add_px(1, 2, 16'h0105, 0);
        add_px(2, 2, 16'h0106, 0);
        pulse_clear(16'h0555);
        run_drain(80);

        add_px(4, 0, 16'h0DDD, 0);
        add_px(0, 3, 16'h0EEE, 0);
        run_drain(40);

        // Reset asserted in the 6th cycle of a clear.
        pulse_clear(16'h1234);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        model_reset();
        src.delete(); gap_left = 0; drive();
        #2 rst_n = 1'b1;

        // Spaced-out frame so render_cycles spans idle gaps.
        for (int i = 0; i < NPIX; i++) add_px(i % FW, i / FW, 16'h2000 + i, (i == 0) ? 0 : 3);
        run_drain(200);
        repeat (5) tick();

        for (int n = 0; n < 400; n++) begin
            if (src.size() < 3)
                add_px($urandom_range(0, FW), $urandom_range(0, FH), $urandom_range(0, 16'hFFFF),
                       $urandom_range(0, 2));
            if ($urandom_range(0, 60) == 0) begin
                clear_color = 16'($urandom);
                clear_start = 1'b1;
            end
            tick();
        end
        run_drain(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/framebuffer_write_scheduler.md
Name: framebuffer_write_scheduler

Overview:
- Owns write port A of the pixel BRAM (the framebuffer).
- Shares that port between two sources: a hardware clear engine that fills the frame with one colour, and the raytracing controller's pixel stream.
- The raytracing stream is buffered in a small FIFO, and its X/Y coordinates are converted to linear addresses.
- Also measures render time and detects frame completion. It replaces the ad-hoc address, write-enable and cycle-count glue in the top level.

Parameters:
- FRAME_WIDTH, 512: pixels per row. Also the row stride.
- FRAME_HEIGHT, 384: rows.
- ADDR_BITS, 18: BRAM address width. Must satisfy 2^ADDR_BITS >= FRAME_WIDTH*FRAME_HEIGHT.
- PIXEL_WIDTH, 16: padded colour width.
- FIFO_DEPTH, 4: ray-write buffer depth. Power of two, >= 2.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous, active-low reset.
- clear_start, input, 1: one-cycle pulse that requests a full-frame clear.
- clear_color, input, PIXEL_WIDTH: fill value. Sampled on the clear_start cycle.
- clear_busy, output, 1: high while the clear engine owns the port.
- ray_valid, input, 1: ray pixel offered.
- ray_ready, output, 1: scheduler can accept a ray pixel.
- ray_x, input, 16: pixel column.
- ray_y, input, 16: pixel row.
- ray_pixel, input, PIXEL_WIDTH: pixel colour.
- bram_we, output, 1: BRAM write enable.
- bram_addr, output, ADDR_BITS: BRAM write address.
- bram_din, output, PIXEL_WIDTH: BRAM write data.
- frame_done, output, 1: one-cycle pulse when the last pixel of the frame is written.
- render_cycles, output, 32: cycles from the first accepted ray pixel to frame_done.
- write_count, output, 32: ray pixels written to the BRAM.
- drop_count, output, 16: ray pixels discarded because their coordinates were out of range.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM returns to IDLE and the FIFO empties.
  - All outputs are 0, except ray_ready, which is 1.
  - Counters clear.
  - A clear in progress is abandoned; it does not resume after reset.
- FSM states: IDLE, CLEAR, RENDER.
  - IDLE to RENDER: on the first accepted ray pixel.
  - IDLE or RENDER to CLEAR: on clear_start.
  - CLEAR to IDLE: after the final clear write.
  - RENDER to IDLE: on the cycle frame_done is asserted.
  - clear_start while already in CLEAR is ignored; clear_color is not re-sampled.
- Handshake:
  - A transfer occurs when ray_valid && ray_ready.
  - ray_ready = !fifo_full, and is independent of ray_valid.
  - A pixel offered while the FIFO is full is not accepted; the source must hold it.
  - Simultaneous push and pop on a full FIFO is not allowed, because ready is low. Simultaneous push and pop otherwise keeps occupancy unchanged.
- Port priority: the clear engine has absolute priority. During CLEAR the FIFO keeps accepting pixels until it is full, but does not drain.
- Ray write path:
  - The FIFO head is popped when the state is not CLEAR.
  - bram_we, bram_addr and bram_din are registered. A pixel accepted into an empty FIFO outside CLEAR is written 1 cycle later.
  - Sustained throughput is 1 write per cycle.
  - Address = FRAME_WIDTH*ray_y + ray_x, computed at full width and truncated to ADDR_BITS.
  - If ray_x >= FRAME_WIDTH or ray_y >= FRAME_HEIGHT, the pixel is popped but not written: bram_we stays low and drop_count increments, saturating at 0xFFFF.
  - write_count increments on every ray write and wraps.
- Clear engine:
  - Starts in the cycle after clear_start.
  - Writes addresses 0 to FRAME_WIDTH*FRAME_HEIGHT-1 in order, one per cycle, with data = the latched clear_color.
  - clear_busy is high for exactly FRAME_WIDTH*FRAME_HEIGHT cycles, aligned with those writes.
  - clear_start also zeroes render_cycles and write_count, and re-arms completion detection.
- Completion:
  - frame_done pulses in the same cycle as the ray write to address FRAME_WIDTH*FRAME_HEIGHT-1.
  - Fires at most once per arm; it is re-armed only by clear_start or reset.
- render_cycles:
  - Starts at 0. Increments every cycle from the cycle after the first accepted ray pixel while armed.
  - Freezes at frame_done and saturates at 0xFFFFFFFF.
- Ray writes after frame_done are still performed and counted.

Test Plan:
Bench uses FRAME_WIDTH=4, FRAME_HEIGHT=3, FIFO_DEPTH=4.
- Reset, then stream (x,y) = (0,0)…(3,2) with colour = index, valid held high. Required: 12 writes at addr 0..11, one per cycle, 1-cycle latency; frame_done on the addr-11 write; write_count = 12.
- clear_start with clear_color = 0x0ABC. Required: clear_busy high for 12 cycles; writes addr 0..11 with 0x0ABC; return to IDLE.
- clear_start and ray_valid for (1,1) in the same cycle, with 5 more pixels queued. Required: 4 pixels accepted, then ray_ready drops; after 12 clear writes, pixel (1,1) is written to addr 5 first.
- Pixels (4,0) and (0,3). Required: no bram_we; drop_count = 2.
- Assert rst_n low at the 6th cycle of a clear. Required: bram_we low immediately; clear_busy = 0; FIFO empty; ray_ready = 1.
- Hold ray_valid low for 3 cycles between pixels. Required: render_cycles equals the cycles from the first acceptance to frame_done, then stays constant.
